uart_frame_resp: RTL and testbench
==================================

# uart_frame_resp

Host-side framed-command responder for the `uart` block. It connects to the `uart` FIFO ports (`rd_uart`/`rx_empty`/`r_data` and `wr_uart`/`tx_full`/`w_data`) and pops received bytes from the RX FIFO. It parses them as SYNC/LEN/payload/checksum frames and pushes an ACK or NAK response into the TX FIFO. It is the consumer and producer on the far side of the UART host interface, and closes the loop for link bring-up and bench loopback.

## Interface

Parameters:
- `SYNC`, 8'hA5, frame start byte
- `MAX_LEN`, 16, largest legal payload length (1..255)
- `TIMEOUT`, 200000, clock cycles without a pop mid-frame before abort (≥ 2; about 4 byte times at DVSR=326)
- `ACK`, 8'h06, positive response code
- `NAK`, 8'h15, negative response code

Ports:
- `clk` in 1: single clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `rx_empty` in 1: RX FIFO empty
- `r_data` in 8: RX FIFO head byte (show-ahead), valid when `rx_empty`=0
- `rd_uart` out 1: RX pop strobe; byte consumed at the clock edge where it is 1
- `tx_full` in 1: TX FIFO full
- `wr_uart` out 1: TX push strobe
- `w_data` out 8: TX byte, valid when `wr_uart`=1
- `frame_ok` out 1: one-cycle pulse when a valid frame is accepted
- `frame_err` out 1: one-cycle pulse on bad length, bad checksum, or timeout
- `err_cnt` out 8: error count, saturates at 255

## Operation

- States: HUNT, LEN, PAYLOAD, CHK, RSP_ACK, RSP_LEN, RSP_SUM, RSP_NAK.
- Pop rule: `rd_uart` = !`rx_empty` && state ∈ {HUNT, LEN, PAYLOAD, CHK}. It is combinational. At most one byte per cycle, and `r_data` is sampled at the same edge.
- Push rule: `wr_uart` = !`tx_full` && state ∈ RSP_*. It is combinational. `w_data` is ACK, the stored len, the sum, or NAK according to state. No RX pops occur during RSP_* states.
- HUNT: pop. If the byte equals SYNC, go to LEN; otherwise discard silently (no error).
- LEN: pop byte b.
  - If b == 0 or b > MAX_LEN: go to RSP_NAK and flag an error.
  - Otherwise: len←b, chk←b, sum←0, cnt←0, go to PAYLOAD.
- PAYLOAD: pop byte b. Update chk←chk^b, sum←sum+b (mod 256), cnt←cnt+1. After the pop where cnt == len-1 (before increment), go to CHK.
- CHK: pop byte b.
  - If b == chk: `frame_ok`, go to RSP_ACK.
  - Otherwise: flag an error, go to RSP_NAK.
- Successful push transitions:
  - RSP_ACK → RSP_LEN
  - RSP_LEN → RSP_SUM
  - RSP_SUM → HUNT
  - RSP_NAK → HUNT
- Timeout:
  - The idle counter clears on entry to LEN and on every pop.
  - It increments on each cycle in LEN/PAYLOAD/CHK without a pop.
  - When it reaches TIMEOUT, go to HUNT and flag an error. No response is sent.
- Flag an error means: `frame_err` pulses for 1 cycle, and `err_cnt` increments unless already 255.
- A pop on the same cycle the timeout would fire wins; the timeout does not fire.

## Timing

- Reset values: state HUNT; `frame_ok`, `frame_err`, `err_cnt`, len, chk, sum, cnt and the idle counter all 0. While `reset_n`=0, `rd_uart`=0, `wr_uart`=0 and `w_data`=0.
- A reset assertion mid-frame or mid-response aborts immediately. Partially sent responses are not resumed.
- `frame_ok` and `frame_err` are registered. They are high during the cycle after the deciding pop or timeout edge.
- Latency from the checksum pop to the ACK push is 1 cycle if `tx_full`=0. The full response takes 3 consecutive cycles with no backpressure.
- Backpressure: `tx_full`=1 holds the RSP_* state, `w_data` stays stable, and no byte is lost or duplicated.
- Back-to-back frames: HUNT is re-entered on the cycle after the last push, and the next SYNC may be popped on that cycle.

## Test plan

1. Good frame: RX A5 03 11 22 33 03 → TX 06 03 66; `frame_ok` pulses once; `err_cnt`=0.
2. Bad checksum: RX A5 02 10 20 FF (expected checksum 32) → TX 15; `frame_err` pulses once; `err_cnt`=1. Then RX A5 01 7E 7F → TX 06 01 7E.
3. Illegal length: RX A5 00 and A5 11 (MAX_LEN=16) → TX 15 15; `err_cnt`=2. Garbage bytes 00 FF before SYNC cause no TX and no error.
4. Backpressure: good frame with `tx_full` held 1 for 50 cycles during RSP_LEN → `wr_uart` stays 0, `w_data`=03 stable, `rd_uart`=0. On release, TX completes 06 03 66 exactly once.
5. Timeout: RX A5 02 10 then nothing for TIMEOUT cycles → HUNT, `frame_err` pulses, no TX. A byte arriving on the timeout cycle is popped and no abort occurs.
6. Reset mid-response: assert `reset_n`=0 between the ACK and LEN pushes → outputs go to 0 immediately. After release, the next good frame gets a full 06/len/sum response. Also drive 300 bad frames → `err_cnt` saturates at 255.

Source files
------------

// File: rtl/uart_frame_resp.sv
// rtl/uart_frame_resp.sv - framed command parser that answers each frame with ACK/len/sum or NAK
module uart_frame_resp #(
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         MAX_LEN = 16,
  parameter int         TIMEOUT = 200000,
  parameter logic [7:0] ACK     = 8'h06,
  parameter logic [7:0] NAK     = 8'h15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [7:0] err_cnt
);

  localparam int            IW        = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [7:0]    MAX_B     = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_RSP_ACK,
    ST_RSP_LEN,
    ST_RSP_SUM,
    ST_RSP_NAK
  } state_t;

  state_t        state;
  logic [7:0]    len;
  logic [7:0]    chk;
  logic [7:0]    sum;
  logic [7:0]    cnt;
  logic [IW-1:0] idle;

  logic in_frame;
  logic rx_phase;
  logic tx_phase;
  logic pop;
  logic push;
  logic bad_len;
  logic chk_match;
  logic timeout_fire;
  logic ok_event;
  logic err_event;

  // Pop/push strobes, response byte select and the per-cycle decision terms
  always_comb begin
    in_frame     = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHK);
    rx_phase     = in_frame || (state == ST_HUNT);
    tx_phase     = !rx_phase;
    pop          = reset_n && !rx_empty && rx_phase;
    push         = reset_n && !tx_full && tx_phase;
    bad_len      = (r_data == 8'd0) || (r_data > MAX_B);
    chk_match    = (r_data == chk);
    // a pop on the deadline cycle keeps the frame alive
    timeout_fire = in_frame && !pop && (idle == IDLE_LAST);
    ok_event     = pop && (state == ST_CHK) && chk_match;
    err_event    = (pop && (state == ST_LEN) && bad_len) ||
                   (pop && (state == ST_CHK) && !chk_match) ||
                   timeout_fire;
    w_data = 8'd0;
    if (reset_n) begin
      case (state)
        ST_RSP_ACK: w_data = ACK;
        ST_RSP_LEN: w_data = len;
        ST_RSP_SUM: w_data = sum;
        ST_RSP_NAK: w_data = NAK;
        default:    w_data = 8'd0;
      endcase
    end
  end

  assign rd_uart = pop;
  assign wr_uart = push;

  // Frame parser / responder state machine with registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_HUNT;
      len       <= 8'd0;
      chk       <= 8'd0;
      sum       <= 8'd0;
      cnt       <= 8'd0;
      idle      <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      frame_ok  <= ok_event;
      frame_err <= err_event;
      if (err_event && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end

      if (pop || !in_frame || timeout_fire) begin
        idle <= '0;
      end else begin
        idle <= idle + IW'(1);
      end

      if (timeout_fire) begin
        state <= ST_HUNT;
      end else begin
        case (state)
          ST_HUNT: begin
            if (pop && (r_data == SYNC)) state <= ST_LEN;
          end
          ST_LEN: begin
            if (pop) begin
              if (bad_len) begin
                state <= ST_RSP_NAK;
              end else begin
                len   <= r_data;
                chk   <= r_data;
                sum   <= 8'd0;
                cnt   <= 8'd0;
                state <= ST_PAYLOAD;
              end
            end
          end
          ST_PAYLOAD: begin
            if (pop) begin
              chk <= chk ^ r_data;
              sum <= sum + r_data;
              cnt <= cnt + 8'd1;
              if (cnt == (len - 8'd1)) state <= ST_CHK;
            end
          end
          ST_CHK: begin
            if (pop) state <= chk_match ? ST_RSP_ACK : ST_RSP_NAK;
          end
          ST_RSP_ACK: begin
            if (push) state <= ST_RSP_LEN;
          end
          ST_RSP_LEN: begin
            if (push) state <= ST_RSP_SUM;
          end
          ST_RSP_SUM: begin
            if (push) state <= ST_HUNT;
          end
          ST_RSP_NAK: begin
            if (push) state <= ST_HUNT;
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_resp.sv
// tb/tb_uart_frame_resp.sv - randomized self-checking bench for uart_frame_resp
module tb_uart_frame_resp;

  localparam logic [7:0] SYNC    = 8'hA5;
  localparam logic [7:0] ACKB    = 8'h06;
  localparam logic [7:0] NAKB    = 8'h15;
  localparam int         MAX_LEN = 16;
  localparam int         TIMEOUT = 40;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'd0;
  logic       tx_full = 1'b0;
  logic       rd_uart;
  logic       wr_uart;
  logic [7:0] w_data;
  logic       frame_ok;
  logic       frame_err;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  uart_frame_resp #(
    .SYNC(SYNC), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT), .ACK(ACKB), .NAK(NAKB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rx_empty(rx_empty), .r_data(r_data),
    .rd_uart(rd_uart), .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_cnt(err_cnt)
  );

  int total = 0;
  int bad = 0;

  byte unsigned rx_q[$];
  byte unsigned tx_log[$];
  byte unsigned exp_tx[$];
  byte unsigned f[$];
  int push_cyc[$];
  int cyc = 0;
  int last_pop_cyc = -1;
  int ok_seen = 0;
  int err_seen = 0;
  int exp_ok = 0;
  int exp_err = 0;
  int exp_errcnt = 0;
  bit bp_rand = 0;
  bit bp_hold = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: present FIFO state at the falling edge, record what the next rising edge does
  task automatic step();
    @(negedge clk);
    rx_empty = (rx_q.size() == 0);
    r_data   = rx_empty ? 8'h00 : rx_q[0];
    tx_full  = bp_hold || (bp_rand && ($urandom_range(0, 2) == 0));
    #1;
    cyc++;
    if (rd_uart && rx_q.size() > 0) begin
      last_pop_cyc = cyc;
      void'(rx_q.pop_front());
    end
    if (wr_uart) begin
      tx_log.push_back(w_data);
      push_cyc.push_back(cyc);
    end
    if (frame_ok) ok_seen++;
    if (frame_err) err_seen++;
  endtask

  task automatic add_err();
    exp_err++;
    if (exp_errcnt < 255) exp_errcnt++;
  endtask

  // Reference: parse a complete byte stream into the responses it must produce
  task automatic model(input byte unsigned s[$]);
    int i = 0;
    int n;
    byte unsigned x;
    byte unsigned sm;
    while (i < s.size()) begin
      if (s[i] != SYNC) begin
        i++;
        continue;
      end
      if (i + 1 >= s.size()) break;
      n = s[i+1];
      i += 2;
      if (n == 0 || n > MAX_LEN) begin
        exp_tx.push_back(NAKB);
        add_err();
        continue;
      end
      if (i + n >= s.size()) break;
      x  = 8'(n);
      sm = 8'd0;
      for (int k = 0; k < n; k++) begin
        x  = x ^ s[i+k];
        sm = sm + s[i+k];
      end
      i += n;
      if (s[i] == x) begin
        exp_tx.push_back(ACKB);
        exp_tx.push_back(8'(n));
        exp_tx.push_back(sm);
        exp_ok++;
      end else begin
        exp_tx.push_back(NAKB);
        add_err();
      end
      i++;
    end
  endtask

  task automatic send(input byte unsigned s[$]);
    foreach (s[i]) rx_q.push_back(s[i]);
    model(s);
  endtask

  task automatic add_frame(input int kind);
    int n;
    byte unsigned x;
    byte unsigned b;
    case (kind)
      0, 1: begin
        n = $urandom_range(1, MAX_LEN);
        f.push_back(SYNC);
        f.push_back(8'(n));
        x = 8'(n);
        for (int k = 0; k < n; k++) begin
          b = 8'($urandom_range(0, 255));
          f.push_back(b);
          x = x ^ b;
        end
        if (kind == 1) x = x ^ 8'($urandom_range(1, 255));
        f.push_back(x);
      end
      2: begin
        f.push_back(SYNC);
        if ($urandom_range(0, 1) == 0) f.push_back(8'd0);
        else f.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
      end
      default: begin
        b = 8'($urandom_range(0, 255));
        if (b == SYNC) b = 8'h00;
        f.push_back(b);
      end
    endcase
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (rx_q.size() > 0 && n < 5000) begin
      step();
      n++;
    end
    check_val({tag, " rx drained"}, rx_q.size(), 0);
    bp_rand = 0;
    bp_hold = 0;
    repeat (8) step();
    check_val({tag, " tx count"}, tx_log.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
      check_val($sformatf("%s tx[%0d]", tag, i), tx_log[i], exp_tx[i]);
    check_val({tag, " ok pulses"}, ok_seen, exp_ok);
    check_val({tag, " err pulses"}, err_seen, exp_err);
    check_val({tag, " err_cnt"}, err_cnt, exp_errcnt);
    tx_log.delete();
    exp_tx.delete();
    push_cyc.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int p;
    int fire;
    int hold_bad;

    // reset state, with a SYNC byte waiting so the pop gate is exercised
    rx_empty = 1'b0;
    r_data   = SYNC;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst rd_uart", rd_uart, 0);
    check_val("rst wr_uart", wr_uart, 0);
    check_val("rst w_data", w_data, 0);
    check_val("rst frame_ok", frame_ok, 0);
    check_val("rst frame_err", frame_err, 0);
    check_val("rst err_cnt", err_cnt, 0);
    @(negedge clk);
    rx_empty = 1'b1;
    reset_n  = 1'b1;

    // good frame, latency and back-to-back response
    f = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send(f);
    n = 0;
    while (tx_log.size() < 3 && n < 100) begin step(); n++; end
    check_val("t1 resp bytes", tx_log.size(), 3);
    if (tx_log.size() >= 3) begin
      check_val("t1 ack", tx_log[0], 8'h06);
      check_val("t1 len", tx_log[1], 8'h03);
      check_val("t1 sum", tx_log[2], 8'h66);
      check_val("t1 ack latency", push_cyc[0] - last_pop_cyc, 1);
      check_val("t1 rsp span", push_cyc[2] - push_cyc[0], 2);
    end
    drain("t1");

    // bad checksum then good frame
    f = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    send(f);
    drain("t2");

    // garbage and illegal lengths
    f = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'hA5, 8'h11};
    send(f);
    drain("t3");

    // backpressure held during RSP_LEN with a second frame queued
    f = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    send(f);
    n = 0;
    while (tx_log.size() < 1 && n < 100) begin step(); n++; end
    check_val("t4 ack before hold", tx_log.size(), 1);
    bp_hold = 1;
    hold_bad = 0;
    repeat (50) begin
      step();
      if (wr_uart !== 1'b0 || w_data !== 8'h03 || rd_uart !== 1'b0) hold_bad++;
    end
    check_val("t4 hold violations", hold_bad, 0);
    check_val("t4 tx during hold", tx_log.size(), 1);
    bp_hold = 0;
    drain("t4");

    // mid-frame timeout
    rx_q.push_back(SYNC); rx_q.push_back(8'h02); rx_q.push_back(8'h10);
    n = 0;
    while (rx_q.size() > 0 && n < 100) begin step(); n++; end
    p = last_pop_cyc;
    fire = -1;
    repeat (TIMEOUT + 3) begin
      step();
      if (frame_err && fire < 0) fire = cyc;
    end
    check_val("t5 abort cycle", fire, p + TIMEOUT + 1);
    add_err();
    drain("t5a");

    // byte arriving exactly on the deadline cycle keeps the frame
    rx_q.push_back(SYNC); rx_q.push_back(8'h02); rx_q.push_back(8'h10);
    n = 0;
    while (rx_q.size() > 0 && n < 100) begin step(); n++; end
    p = last_pop_cyc;
    repeat (TIMEOUT - 1) step();
    rx_q.push_back(8'h20); rx_q.push_back(8'h32);
    exp_tx.push_back(ACKB); exp_tx.push_back(8'h02); exp_tx.push_back(8'h30);
    exp_ok++;
    step();
    check_val("t5b deadline pop", last_pop_cyc, p + TIMEOUT);
    drain("t5b");

    // randomized frame mix under random backpressure
    for (int b = 0; b < 3; b++) begin
      f.delete();
      repeat (40) add_frame($urandom_range(0, 3));
      send(f);
      bp_rand = 1;
      drain($sformatf("rand%0d", b));
    end

    // reset between the ACK and LEN pushes
    rx_q.push_back(8'hA5); rx_q.push_back(8'h03); rx_q.push_back(8'h11);
    rx_q.push_back(8'h22); rx_q.push_back(8'h33); rx_q.push_back(8'h03);
    n = 0;
    while (tx_log.size() < 1 && n < 100) begin step(); n++; end
    check_val("t6 ack seen", tx_log.size(), 1);
    exp_ok++;
    @(posedge clk);
    #1;
    rx_empty = 1'b0;
    r_data   = SYNC;
    reset_n  = 1'b0;
    #1;
    check_val("t6 rst wr_uart", wr_uart, 0);
    check_val("t6 rst w_data", w_data, 0);
    check_val("t6 rst rd_uart", rd_uart, 0);
    check_val("t6 rst err_cnt", err_cnt, 0);
    @(negedge clk);
    rx_empty = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    tx_log.delete();
    push_cyc.delete();
    rx_q.delete();
    exp_errcnt = 0;
    f = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send(f);
    drain("t6");

    // error counter saturation
    f.delete();
    repeat (300) add_frame(2);
    send(f);
    drain("sat");
    check_val("sat err_cnt", err_cnt, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
